// File: rtl/arithmetic_fu_pipe_if.sv
// rtl/arithmetic_fu_pipe_if.sv - issue/result bundle between reservation station, ALU unit and CDB arbiter
// Purpose: groups the issue side (flush, valid/ready, uop, tags, operands) and the
//          result side (valid/ready, result, tags, illegal) of arithmetic_fu_pipe.
// Modports:
//   master - reservation station / CDB view: drives issue fields and out_ready
//   slave  - functional unit view: drives in_ready and all result fields
interface arithmetic_fu_pipe_if #(
  parameter int XLEN          = 32,
  parameter int ROB_SIZE      = 256,
  parameter int PHYS_REG_SIZE = 256,
  parameter int UOP_SIZE      = 16
);
  localparam int ROB_W = $clog2(ROB_SIZE);
  localparam int TAG_W = $clog2(PHYS_REG_SIZE);
  localparam int UOP_W = $clog2(UOP_SIZE);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [UOP_W-1:0] uop;
  logic [ROB_W-1:0] rob_entry_in;
  logic [TAG_W-1:0] dest_reg_in;
  logic [XLEN-1:0]  rs1;
  logic [XLEN-1:0]  rs2;
  logic [XLEN-1:0]  pc;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [ROB_W-1:0] rob_entry;
  logic [TAG_W-1:0] dest_reg;
  logic             illegal;

  modport master (
    output flush, in_valid, uop, rob_entry_in, dest_reg_in, rs1, rs2, pc, out_ready,
    input  in_ready, out_valid, result, rob_entry, dest_reg, illegal
  );

  modport slave (
    input  flush, in_valid, uop, rob_entry_in, dest_reg_in, rs1, rs2, pc, out_ready,
    output in_ready, out_valid, result, rob_entry, dest_reg, illegal
  );
endinterface

// File: rtl/arithmetic_fu_pipe.sv
// rtl/arithmetic_fu_pipe.sv - pipelined RV32I/RV64I integer ALU functional unit
// Purpose: computes one ALU micro-op per cycle combinationally at issue, then carries
//          {valid, result, rob tag, dest tag, illegal} through STAGES elastic registers.
// Ports:
//   clk - clock
//   rst - synchronous active-high reset, clears every stage (valid and data)
//   bus - arithmetic_fu_pipe_if.slave: flush, in_valid/in_ready, uop, rob_entry_in,
//         dest_reg_in, rs1, rs2, pc in; out_valid/out_ready, result, rob_entry,
//         dest_reg, illegal out (driven straight from the last stage registers)
module arithmetic_fu_pipe #(
  parameter int XLEN          = 32,
  parameter int ROB_SIZE      = 256,
  parameter int PHYS_REG_SIZE = 256,
  parameter int UOP_SIZE      = 16,
  parameter int STAGES        = 2
) (
  input logic clk,
  input logic rst,
  arithmetic_fu_pipe_if.slave bus
);
  localparam int ROB_W = $clog2(ROB_SIZE);
  localparam int TAG_W = $clog2(PHYS_REG_SIZE);
  localparam int UOP_W = $clog2(UOP_SIZE);
  localparam int SH_W  = $clog2(XLEN);

  localparam logic [UOP_W-1:0] UOP_ADD   = UOP_W'(0);
  localparam logic [UOP_W-1:0] UOP_SUB   = UOP_W'(1);
  localparam logic [UOP_W-1:0] UOP_SLT   = UOP_W'(2);
  localparam logic [UOP_W-1:0] UOP_SLTU  = UOP_W'(3);
  localparam logic [UOP_W-1:0] UOP_AND   = UOP_W'(4);
  localparam logic [UOP_W-1:0] UOP_OR    = UOP_W'(5);
  localparam logic [UOP_W-1:0] UOP_XOR   = UOP_W'(6);
  localparam logic [UOP_W-1:0] UOP_SLL   = UOP_W'(7);
  localparam logic [UOP_W-1:0] UOP_SRL   = UOP_W'(8);
  localparam logic [UOP_W-1:0] UOP_SRA   = UOP_W'(9);
  localparam logic [UOP_W-1:0] UOP_LUI   = UOP_W'(10);
  localparam logic [UOP_W-1:0] UOP_AUIPC = UOP_W'(11);

  logic [SH_W-1:0]   shamt;
  logic [XLEN-1:0]   alu_res;
  logic              alu_ill;
  logic              accept;

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] ld;
  logic [XLEN-1:0]   res_q  [STAGES];
  logic [ROB_W-1:0]  rob_q  [STAGES];
  logic [TAG_W-1:0]  dest_q [STAGES];
  logic              ill_q  [STAGES];

  assign shamt = bus.rs2[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (bus.uop)
      UOP_ADD:   alu_res = bus.rs1 + bus.rs2;
      UOP_SUB:   alu_res = bus.rs1 - bus.rs2;
      UOP_SLT:   alu_res = XLEN'($signed(bus.rs1) < $signed(bus.rs2));
      UOP_SLTU:  alu_res = XLEN'(bus.rs1 < bus.rs2);
      UOP_AND:   alu_res = bus.rs1 & bus.rs2;
      UOP_OR:    alu_res = bus.rs1 | bus.rs2;
      UOP_XOR:   alu_res = bus.rs1 ^ bus.rs2;
      UOP_SLL:   alu_res = bus.rs1 << shamt;
      UOP_SRL:   alu_res = bus.rs1 >> shamt;
      UOP_SRA:   alu_res = $unsigned($signed(bus.rs1) >>> shamt);
      UOP_LUI:   alu_res = bus.rs2;
      UOP_AUIPC: alu_res = bus.pc + bus.rs2;
      default:   alu_ill = 1'b1;
    endcase
  end

  // Stage k can load when some stage at or beyond k is empty (the chain in front of
  // it collapses into that hole) or when the result is taken this cycle.
  for (genvar k = 0; k < STAGES; k++) begin : g_ld
    assign ld[k] = !(&vld[STAGES-1:k]) || bus.out_ready;
  end

  assign accept = bus.in_valid && ld[0] && !bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int k = 0; k < STAGES; k++) begin
        res_q[k]  <= '0;
        rob_q[k]  <= '0;
        dest_q[k] <= '0;
        ill_q[k]  <= 1'b0;
      end
    end else begin
      if (ld[0]) begin
        vld[0] <= accept;
        if (accept) begin
          res_q[0]  <= alu_res;
          rob_q[0]  <= bus.rob_entry_in;
          dest_q[0] <= bus.dest_reg_in;
          ill_q[0]  <= alu_ill;
        end
      end
      // Data only moves with a valid op, so a stalled last stage and bubbles never
      // disturb the registers feeding the outputs.
      for (int k = 1; k < STAGES; k++) begin
        if (ld[k]) begin
          vld[k] <= vld[k-1];
          if (vld[k-1]) begin
            res_q[k]  <= res_q[k-1];
            rob_q[k]  <= rob_q[k-1];
            dest_q[k] <= dest_q[k-1];
            ill_q[k]  <= ill_q[k-1];
          end
        end
      end
      if (bus.flush) begin
        vld <= '0;
      end
    end
  end

  assign bus.in_ready  = ld[0];
  assign bus.out_valid = vld[STAGES-1];
  assign bus.result    = res_q[STAGES-1];
  assign bus.rob_entry = rob_q[STAGES-1];
  assign bus.dest_reg  = dest_q[STAGES-1];
  assign bus.illegal   = ill_q[STAGES-1];
endmodule
